add_share_sched: RTL and testbench

//  Shares one pipelined adder (add_in -> add_out datapath) between NUM_REQ requesters.

---
 rtl/add_sched_pkg.sv | 23 ++
 rtl/add_share_sched_arbiter.sv | 31 +++
 rtl/add_share_sched.sv | 109 ++++++++++
 tb/tb_add_share_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sched_pkg.sv
// Shared types for the adder-sharing scheduler: FSM states, in-flight tag
// record and the requester-id width helper.
package add_sched_pkg;

    // Wide enough for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/add_share_sched_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
// The pointer register is owned by the parent.
module add_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               found
);

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/add_share_sched.sv
// Shares one pipelined adder between NUM_REQ requesters with round-robin
// issue, tags each op with its requester id and routes the sum back.
//
//   state | meaning
//   IDLE  | nothing granted, pipe empty
//   RUN   | granting one request per cycle
//   DRAIN | no new grants, waiting for in-flight ops to return
module add_share_sched
    import add_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          add_en,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH:0]           add_sum,
    input  logic                          add_sum_valid,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH:0]           rsp_sum,
    output logic                          busy,
    output logic                          err_latency
);

    localparam int ID_W = id_w(NUM_REQ);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    issue_id_q;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic               tags_busy;
    logic               pipe_empty;
    tag_t               tag_pipe_q [ADD_LATENCY];
    tag_t               tail;

    add_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      ((state_q == RUN) ? req_valid : '0),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .found    (xfer)
    );

    assign req_ready = grant;
    assign tail      = tag_pipe_q[ADD_LATENCY-1];

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < ADD_LATENCY; i++) tags_busy = tags_busy | tag_pipe_q[i].valid;
    end

    // An op in the issue register has not reached the tag pipe yet but is in flight.
    assign pipe_empty = !tags_busy && !add_en;
    assign busy       = (state_q != IDLE) || !pipe_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_enable) state_d = RUN;
            RUN:     if (!cfg_enable) state_d = DRAIN;
            DRAIN:   if (cfg_enable) state_d = RUN;
                     else if (pipe_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            issue_id_q  <= '0;
            add_en      <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            rsp_valid   <= '0;
            rsp_sum     <= '0;
            err_latency <= 1'b0;
            for (int i = 0; i < ADD_LATENCY; i++) tag_pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            add_en  <= xfer;
            if (xfer) begin
                rr_ptr_q   <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                issue_id_q <= grant_id;
                add_a      <= req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
                add_b      <= req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
            end
            tag_pipe_q[0] <= '{valid: add_en, id: MAX_ID_W'(issue_id_q)};
            for (int i = 1; i < ADD_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
            rsp_valid <= tail.valid ? (NUM_REQ'(1) << tail.id) : '0;
            if (tail.valid) rsp_sum <= add_sum;
            if (tail.valid != add_sum_valid) err_latency <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add_share_sched.sv
// Directed bench for add_share_sched with a behavioural two-stage adder.
module tb_add_share_sched;

    localparam int NUM_REQ     = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int ADD_LATENCY = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          cfg_enable;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          add_en;
    logic [DATA_WIDTH-1:0]         add_a;
    logic [DATA_WIDTH-1:0]         add_b;
    logic [DATA_WIDTH:0]           add_sum;
    logic                          add_sum_valid;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH:0]           rsp_sum;
    logic                          busy;
    logic                          err_latency;
    logic                          extra_delay;

    add_share_sched #(
        .NUM_REQ     (NUM_REQ),
        .DATA_WIDTH  (DATA_WIDTH),
        .ADD_LATENCY (ADD_LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .add_en        (add_en),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_sum       (add_sum),
        .add_sum_valid (add_sum_valid),
        .rsp_valid     (rsp_valid),
        .rsp_sum       (rsp_sum),
        .busy          (busy),
        .err_latency   (err_latency)
    );

    always #5 clk = ~clk;

    // Adder model: two-cycle latency, optionally one cycle late on the strobe.
    logic [2:0]          av;
    logic [DATA_WIDTH:0] as0, as1, as2;
    always @(posedge clk) begin
        if (rst) av <= '0;
        else     av <= {av[1:0], add_en};
        as0 <= {1'b0, add_a} + {1'b0, add_b};
        as1 <= as0;
        as2 <= as1;
    end
    assign add_sum_valid = extra_delay ? av[2] : av[1];
    assign add_sum       = extra_delay ? as2 : as1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                  cyc;
        logic [NUM_REQ-1:0]  v;
        logic [DATA_WIDTH:0] s;
    } rsp_t;
    rsp_t rsp_q[$];

    always @(posedge clk) begin
        rsp_t r;
        #3;
        if (rsp_valid != '0) begin
            r.cyc = cyc;
            r.v   = rsp_valid;
            r.s   = rsp_sum;
            rsp_q.push_back(r);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*DATA_WIDTH +: DATA_WIDTH] = a;
        req_b[id*DATA_WIDTH +: DATA_WIDTH] = b;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ready"}, 32'(req_ready), 0);
        chk({pfx, "_add_en"}, 32'(add_en), 0);
        chk({pfx, "_add_a"}, 32'(add_a), 0);
        chk({pfx, "_add_b"}, 32'(add_b), 0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({pfx, "_rsp_sum"}, 32'(rsp_sum), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_err"}, 32'(err_latency), 0);
    endtask

    typedef struct {
        int                  id;
        logic [7:0]          a;
        logic [7:0]          b;
        logic [DATA_WIDTH:0] sum;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   w;
        vecs[0] = '{id: 2, a: 8'hFF, b: 8'h01, sum: 9'h100};
        vecs[1] = '{id: 0, a: 8'hFF, b: 8'hFF, sum: 9'h1FE};
        vecs[2] = '{id: 3, a: 8'h00, b: 8'h00, sum: 9'h000};
        vecs[3] = '{id: 1, a: 8'h7F, b: 8'h01, sum: 9'h080};
        vecs[4] = '{id: 2, a: 8'hA5, b: 8'h5A, sum: 9'h0FF};

        rst = 1'b1; cfg_enable = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        extra_delay = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        // All four requesters valid from reset: strict 0,1,2,3 rotation.
        rst = 1'b0; cfg_enable = 1'b1; req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(16 * (i + 1)), 8'(i + 1));
        #1;
        chk("rr_idle_ready", 32'(req_ready), 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
        chk("rr_rsp_count", 32'(rsp_q.size()), 8);
        for (int k = 0; k < 8 && k < rsp_q.size(); k++) begin
            chk($sformatf("rr_rsp_id_%0d", k), 32'(rsp_q[k].v), 32'(1 << (k % 4)));
            chk($sformatf("rr_rsp_sum_%0d", k), 32'(rsp_q[k].s), 32'(17 * (k % 4 + 1)));
            chk($sformatf("rr_rsp_cyc_%0d", k), 32'(rsp_q[k].cyc), 32'(rsp_q[0].cyc + k));
        end

        // Pointer moved to 2 by a grant to requester 1; then 1 and 3 compete.
        rsp_q.delete();
        req_valid = 4'b0010; set_op(1, 8'h21, 8'h01);
        #1; chk("ptr_setup_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1010; set_op(3, 8'h30, 8'h05); set_op(1, 8'h40, 8'h02);
        #1; chk("ptr_first_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0010;
        #1; chk("ptr_second_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1111;
        #1; chk("ptr_end_at_2", 32'(req_ready), 32'h4);
        req_valid = '0;
        repeat (6) tick();
        chk("ptr_rsp_count", 32'(rsp_q.size()), 3);
        if (rsp_q.size() == 3) begin
            chk("ptr_rsp0", {rsp_q[0].v, 23'(rsp_q[0].s)}, {4'b0010, 23'h022});
            chk("ptr_rsp1", {rsp_q[1].v, 23'(rsp_q[1].s)}, {4'b1000, 23'h035});
            chk("ptr_rsp2", {rsp_q[2].v, 23'(rsp_q[2].s)}, {4'b0010, 23'h042});
        end

        // Drain: cfg_enable falls while requester 1 is being granted.
        set_op(0, 8'h11, 8'h22); set_op(1, 8'h80, 8'h80);
        req_valid = 4'b0011;
        #1; chk("drain_t0_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010; cfg_enable = 1'b0;
        #1; chk("drain_t1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0011;
        #1;
        chk("drain_t2_ready", 32'(req_ready), 0);
        chk("drain_t2_add_en", 32'(add_en), 1);
        chk("drain_t2_busy", 32'(busy), 1);
        tick();
        chk("drain_t3_ready", 32'(req_ready), 0);
        chk("drain_t3_busy", 32'(busy), 1);
        tick();
        chk("drain_t4_rsp", {rsp_valid, 23'(rsp_sum)}, {4'b0001, 23'h033});
        chk("drain_t4_busy", 32'(busy), 1);
        tick();
        chk("drain_t5_rsp", {rsp_valid, 23'(rsp_sum)}, {4'b0010, 23'h100});
        chk("drain_t5_busy", 32'(busy), 1);
        tick();
        chk("drain_t6_busy", 32'(busy), 0);
        chk("drain_t6_rsp", 32'(rsp_valid), 0);
        chk("drain_t6_ready", 32'(req_ready), 0);
        req_valid = '0;

        // Single-request vectors: issue at T+1, response at T+4.
        cfg_enable = 1'b1;
        tick();
        foreach (vecs[v]) begin
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = NUM_REQ'(1) << vecs[v].id;
            #1;
            w = 0;
            while (!req_ready[vecs[v].id] && w < 10) begin
                tick();
                w++;
            end
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
            tick();
            req_valid = '0;
            chk($sformatf("vec%0d_add_en", v), 32'(add_en), 1);
            chk($sformatf("vec%0d_add_ab", v), {add_a, add_b}, {vecs[v].a, vecs[v].b});
            tick(); tick();
            chk($sformatf("vec%0d_rsp_early", v), 32'(rsp_valid), 0);
            tick();
            chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(1 << vecs[v].id));
            chk($sformatf("vec%0d_rsp_sum", v), 32'(rsp_sum), 32'(vecs[v].sum));
            tick();
        end

        // Adder strobe one cycle late: sticky error, stray strobe ignored.
        extra_delay = 1'b1;
        set_op(0, 8'h01, 8'h02);
        req_valid = 4'b0001;
        #1; chk("lat_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick(); tick();
        chk("lat_err_t3", 32'(err_latency), 0);
        tick();
        chk("lat_err_t4", 32'(err_latency), 1);
        chk("lat_rsp_t4", 32'(rsp_valid), 32'h1);
        tick();
        chk("lat_stray_rsp", 32'(rsp_valid), 0);
        extra_delay = 1'b0;
        repeat (4) tick();
        chk("lat_err_sticky", 32'(err_latency), 1);

        // Reset with three ops in flight.
        req_valid = 4'b1111;
        #1;
        tick(); tick(); tick();
        req_valid = '0; rst = 1'b1; cfg_enable = 1'b0;
        rsp_q.delete();
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        repeat (6) tick();
        chk("midrst_no_rsp", 32'(rsp_q.size()), 0);
        cfg_enable = 1'b1; req_valid = 4'b1111;
        tick();
        chk("midrst_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
